// File: rtl/booth_pkg.sv
// Shared definitions for the Booth multiplier arbiter: FSM encoding and
// the packed-operand slice helper.
`ifndef BOOTH_PKG_SV
`define BOOTH_PKG_SV

// Select requester idx's w-bit field from a packed per-requester vector.
`define BOOTH_SLICE(vec, idx, w) vec[(idx)*(w) +: (w)]

package booth_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  // Watchdog counter width; TIMEOUT is bounded below 256.
  localparam int WDOG_W = 8;

endpackage

`endif

// File: rtl/booth_arbiter_rr_pick.sv
// Round-robin picker: lowest set request at or after ptr, wrapping at NREQ.
module rr_pick
  import booth_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int PTR_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [PTR_W-1:0] idx,
  output logic             vld
);

  localparam int PW1 = PTR_W + 1;

  logic [PTR_W:0] pos;

  // Scan from the farthest candidate back to ptr so the nearest hit wins.
  always_comb begin
    idx = '0;
    vld = 1'b0;
    pos = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      pos = {1'b0, ptr} + PW1'(k);
      if (pos >= PW1'(NREQ)) pos = pos - PW1'(NREQ);
      if (req[pos[PTR_W-1:0]]) begin
        idx = pos[PTR_W-1:0];
        vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/booth_arbiter.sv
// Round-robin front end that shares one sequential Booth multiplier among
// NREQ requesters, with a watchdog that aborts a multiplier that never
// signals done.
module booth_arbiter
  import booth_pkg::*;
#(
  parameter int W       = 5,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 31
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ*W-1:0]   op_a,
  input  logic [NREQ*W-1:0]   op_b,
  output logic [NREQ-1:0]     ack,
  output logic [2*W-1:0]      res,
  output logic                err,
  output logic                busy,
  output logic [W-1:0]        mul_a,
  output logic [W-1:0]        mul_b,
  output logic                mul_start,
  input  logic [2*W-1:0]      mul_c,
  input  logic                mul_done
);

  localparam int PTR_W = $clog2(NREQ);

  state_t                  state_q, state_d;
  logic [PTR_W-1:0]        ptr_q, ptr_d;
  logic [PTR_W-1:0]        gnt_q, gnt_d;
  logic [NREQ-1:0]         ack_q, ack_d;
  logic signed [2*W-1:0]   res_q, res_d;
  logic                    err_q, err_d;
  logic                    busy_q, busy_d;
  logic                    start_q, start_d;
  logic signed [W-1:0]     mul_a_q, mul_a_d;
  logic signed [W-1:0]     mul_b_q, mul_b_d;
  logic [WDOG_W-1:0]       wdog_q, wdog_d;

  logic [PTR_W-1:0]        pick_idx;
  logic                    pick_vld;

  rr_pick #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req (req),
    .ptr (ptr_q),
    .idx (pick_idx),
    .vld (pick_vld)
  );

  // Next-state and registered-output computation for the service FSM.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    ack_d   = '0;
    res_d   = res_q;
    err_d   = err_q;
    start_d = 1'b0;
    mul_a_d = mul_a_q;
    mul_b_d = mul_b_q;
    wdog_d  = wdog_q;

    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          gnt_d   = pick_idx;
          mul_a_d = `BOOTH_SLICE(op_a, pick_idx, W);
          mul_b_d = `BOOTH_SLICE(op_b, pick_idx, W);
          start_d = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        wdog_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        wdog_d = wdog_q + 1'b1;
        // wdog_q == 0 marks the first WAIT cycle, where a done still
        // asserted from the previous product must not be trusted.
        if (mul_done && (wdog_q != '0)) begin
          res_d   = mul_c;
          err_d   = 1'b0;
          ack_d[gnt_q] = 1'b1;
          state_d = S_RESP;
        end else if (wdog_q == WDOG_W'(TIMEOUT - 1)) begin
          res_d   = '0;
          err_d   = 1'b1;
          ack_d[gnt_q] = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        res_d = '0;
        err_d = 1'b0;
        if (gnt_q == PTR_W'(NREQ - 1)) ptr_d = '0;
        else                           ptr_d = gnt_q + 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      ack_q   <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      start_q <= 1'b0;
      mul_a_q <= '0;
      mul_b_q <= '0;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      res_q   <= res_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      start_q <= start_d;
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
      wdog_q  <= wdog_d;
    end
  end

  assign ack       = ack_q;
  assign res       = res_q;
  assign err       = err_q;
  assign busy      = busy_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign mul_start = start_q;

endmodule

// File: tb/tb_booth_arbiter.sv
// Directed bench for booth_arbiter with a behavioural sequential multiplier.
module tb_booth_arbiter;

  localparam int W       = 5;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 31;

  logic                 clk;
  logic                 rst;
  logic [NREQ-1:0]      req;
  logic [NREQ*W-1:0]    op_a;
  logic [NREQ*W-1:0]    op_b;
  logic [NREQ-1:0]      ack;
  logic [2*W-1:0]       res;
  logic                 err;
  logic                 busy;
  logic [W-1:0]         mul_a;
  logic [W-1:0]         mul_b;
  logic                 mul_start;
  logic [2*W-1:0]       mul_c;
  logic                 mul_done;

  int checks;
  int passed;
  int mode;  // 0 normal, 1 done clears one cycle late, 2 done stuck low

  booth_arbiter #(.W(W), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .op_a      (op_a),
    .op_b      (op_b),
    .ack       (ack),
    .res       (res),
    .err       (err),
    .busy      (busy),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_start (mul_start),
    .mul_c     (mul_c),
    .mul_done  (mul_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Multiplier model: active-low reset driven by inverted mul_start,
  // product ready W cycles later, done held until the next reset.
  logic                  m_rst_n;
  logic signed [2*W-1:0] m_c;
  logic                  m_done_q, m_done_dly;
  logic [3:0]            m_cnt;
  assign m_rst_n = ~mul_start;

  always @(posedge clk) begin
    m_done_dly <= m_done_q;
    if (rst || !m_rst_n) begin
      m_cnt    <= '0;
      m_done_q <= 1'b0;
      m_c      <= '0;
    end else if (!m_done_q) begin
      if (m_cnt == 4'(W - 1)) begin
        m_done_q <= 1'b1;
        m_c      <= $signed(mul_a) * $signed(mul_b);
      end
      m_cnt <= m_cnt + 1'b1;
    end
  end

  assign mul_c    = m_c;
  assign mul_done = (mode == 2) ? 1'b0 :
                    (mode == 1) ? (m_done_q | m_done_dly) : m_done_q;

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_ack(input int budget, output logic [NREQ-1:0] a,
                          output logic [2*W-1:0] r, output logic e,
                          output int cyc);
    a = '0; r = '0; e = 1'b0; cyc = -1;
    for (int n = 1; n <= budget; n++) begin
      @(negedge clk);
      if (ack !== '0) begin
        a = ack; r = res; e = err; cyc = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; op_a = '0; op_b = '0; mode = 0;
    @(negedge clk);
    checks++;
    if ({ack, res, err, busy} !== '0)
      $display("FAIL reset_outs: got ack=%b res=%b err=%b busy=%b want all 0", ack, res, err, busy);
    else passed++;
    checks++;
    if ({mul_a, mul_b, mul_start} !== '0)
      $display("FAIL reset_mul: got a=%b b=%b start=%b want all 0", mul_a, mul_b, mul_start);
    else passed++;
    checks++;
    if (dut.ptr_q !== 2'd0) $display("FAIL reset_ptr: got %0d want 0", dut.ptr_q);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) $display("FAIL reset_idle_busy: got %b want 0", busy);
    else passed++;
  endtask

  task automatic test_single();
    logic [NREQ-1:0] a; logic [2*W-1:0] r; logic e; int cyc;
    op_a[0*W +: W] = 5'b00010;
    op_b[0*W +: W] = 5'b11110;
    req = 4'b0001;
    repeat (3) @(negedge clk);
    op_a[0*W +: W] = 5'b01111;  // changed after grant: must not matter
    wait_ack(60, a, r, e, cyc);
    req = 4'b0000;
    checks++;
    if (a !== 4'b0001) $display("FAIL single_ack: got %b want 0001", a); else passed++;
    checks++;
    if (r !== 10'b1111111100) $display("FAIL single_res: got %b want 1111111100", r); else passed++;
    checks++;
    if (e !== 1'b0) $display("FAIL single_err: got %b want 0", e); else passed++;
    checks++;
    if (cyc + 3 !== 8) $display("FAIL single_latency: got %0d want 8", cyc + 3); else passed++;
    @(negedge clk);
    checks++;
    if ({ack, res, err, busy} !== '0)
      $display("FAIL single_after: got ack=%b res=%b err=%b busy=%b want all 0", ack, res, err, busy);
    else passed++;
  endtask

  task automatic test_simultaneous();
    logic [NREQ-1:0] a; logic [2*W-1:0] r; logic e; int cyc;
    logic [NREQ-1:0] exp_a [4];
    logic [2*W-1:0]  exp_r [4];
    exp_a = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    exp_r = '{10'd48, 10'd4, 10'd45, 10'd256};
    do_reset();
    op_a[0*W +: W] = 5'd6;  op_b[0*W +: W] = 5'd8;
    op_a[1*W +: W] = 5'd4;  op_b[1*W +: W] = 5'd1;
    op_a[2*W +: W] = 5'd5;  op_b[2*W +: W] = 5'd9;
    op_a[3*W +: W] = 5'b10000; op_b[3*W +: W] = 5'b10000;
    req = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      wait_ack(60, a, r, e, cyc);
      req = req & ~a;
      checks++;
      if (a !== exp_a[i] || r !== exp_r[i] || e !== 1'b0)
        $display("FAIL simul_%0d: got ack=%b res=%0d err=%b want ack=%b res=%0d err=0",
                 i, a, $signed(r), e, exp_a[i], $signed(exp_r[i]));
      else passed++;
    end
    req = '0;
    @(negedge clk);
  endtask

  task automatic test_fairness();
    logic [NREQ-1:0] a; logic [2*W-1:0] r; logic e; int cyc;
    logic [NREQ-1:0] exp_a [4];
    logic [2*W-1:0]  exp_r [4];
    exp_a = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};
    exp_r = '{10'd6, -10'sd21, 10'd6, -10'sd21};
    op_a[0*W +: W] = 5'd3;      op_b[0*W +: W] = 5'd2;
    op_a[2*W +: W] = 5'b11101;  op_b[2*W +: W] = 5'd7;
    req = 4'b0001;
    repeat (3) @(negedge clk);
    req = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      wait_ack(60, a, r, e, cyc);
      if (i == 3) req = '0;
      checks++;
      if (a !== exp_a[i] || r !== exp_r[i])
        $display("FAIL fair_%0d: got ack=%b res=%0d want ack=%b res=%0d",
                 i, a, $signed(r), exp_a[i], $signed(exp_r[i]));
      else passed++;
      if (i == 0) begin
        @(negedge clk);
        checks++;
        if (dut.ptr_q !== 2'd1) $display("FAIL fair_ptr: got %0d want 1", dut.ptr_q);
        else passed++;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_stale_done();
    logic [NREQ-1:0] a; logic [2*W-1:0] r; logic e; int cyc;
    mode = 1;
    op_a[0*W +: W] = 5'd6; op_b[0*W +: W] = 5'd8;
    req = 4'b0001;
    wait_ack(60, a, r, e, cyc);
    req = '0;
    checks++;
    if (a !== 4'b0001 || r !== 10'd48)
      $display("FAIL stale_result: got ack=%b res=%0d want ack=0001 res=48", a, $signed(r));
    else passed++;
    checks++;
    if (cyc !== 8) $display("FAIL stale_latency: got %0d want 8", cyc); else passed++;
    mode = 0;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    logic [NREQ-1:0] a; logic [2*W-1:0] r; logic e; int cyc;
    mode = 2;
    op_a[2*W +: W] = 5'd3; op_b[2*W +: W] = 5'd3;
    req = 4'b0100;
    wait_ack(TIMEOUT + 20, a, r, e, cyc);
    req = '0;
    checks++;
    if (a !== 4'b0100 || e !== 1'b1 || r !== '0)
      $display("FAIL timeout_resp: got ack=%b err=%b res=%0d want ack=0100 err=1 res=0", a, e, r);
    else passed++;
    checks++;
    if (cyc !== TIMEOUT + 2) $display("FAIL timeout_latency: got %0d want %0d", cyc, TIMEOUT + 2);
    else passed++;
    mode = 0;
    @(negedge clk);
    checks++;
    if (err !== 1'b0 || ack !== '0) $display("FAIL timeout_clear: got err=%b ack=%b want 0/0000", err, ack);
    else passed++;
    req = 4'b0100;
    wait_ack(60, a, r, e, cyc);
    req = '0;
    checks++;
    if (a !== 4'b0100 || e !== 1'b0 || r !== 10'd9)
      $display("FAIL timeout_recover: got ack=%b err=%b res=%0d want ack=0100 err=0 res=9", a, e, $signed(r));
    else passed++;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [NREQ-1:0] a; logic [2*W-1:0] r; logic e; int cyc;
    // ptr is 3 here, so requester 3 wins the first grant.
    op_a[1*W +: W] = 5'd2; op_b[1*W +: W] = 5'b11101;
    op_a[3*W +: W] = 5'd7; op_b[3*W +: W] = 5'd7;
    req = 4'b1010;
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || mul_a !== 5'd7)
      $display("FAIL rstmid_grant: got busy=%b mul_a=%0d want busy=1 mul_a=7", busy, mul_a);
    else passed++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({ack, res, err, busy, mul_a, mul_b, mul_start} !== '0)
      $display("FAIL rstmid_outs: got ack=%b res=%b err=%b busy=%b a=%b b=%b start=%b want all 0",
               ack, res, err, busy, mul_a, mul_b, mul_start);
    else passed++;
    wait_ack(60, a, r, e, cyc);
    req = req & ~a;
    checks++;
    if (a !== 4'b0010 || r !== -10'sd6)
      $display("FAIL rstmid_regrant: got ack=%b res=%0d want ack=0010 res=-6", a, $signed(r));
    else passed++;
    wait_ack(60, a, r, e, cyc);
    req = req & ~a;
    checks++;
    if (a !== 4'b1000 || r !== 10'd49)
      $display("FAIL rstmid_next: got ack=%b res=%0d want ack=1000 res=49", a, $signed(r));
    else passed++;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) $display("FAIL rstmid_idle: got busy=%b want 0", busy); else passed++;
  endtask

  initial begin
    checks = 0;
    passed = 0;
    mode   = 0;
    test_reset();
    test_single();
    test_simultaneous();
    test_fairness();
    test_stale_done();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/booth_arbiter.md
Name: booth_arbiter

Overview:
- Round-robin scheduler that shares one sequential Booth multiplier between NREQ requesters.
- Latches the winning requester's operands and issues a one-cycle start to the multiplier.
- Waits for the multiplier's done, then returns the signed product with a one-cycle ack to the winner.
- Sits between the client blocks and the single multiplier instance; a watchdog flags a multiplier that never finishes.

Parameters:
- W, 5, operand width in bits (two's complement).
- NREQ, 4, number of requesters (2..8).
- TIMEOUT, 31, maximum cycles in WAIT before abort; needs W+2 <= TIMEOUT < 256.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- req  input  NREQ  per-requester request level
- op_a  input  NREQ*W  operand a, requester i at bits [i*W +: W]
- op_b  input  NREQ*W  operand b, same packing
- ack  output  NREQ  one-hot, one-cycle completion pulse
- res  output  2W  product for the acked requester, valid while ack is nonzero
- err  output  1  high with ack when the product is invalid because of a timeout
- busy  output  1  high in any state other than IDLE
- mul_a  output  W  operand a to the multiplier
- mul_b  output  W  operand b to the multiplier
- mul_start  output  1  one-cycle start pulse to the multiplier
- mul_c  input  2W  multiplier product
- mul_done  input  1  multiplier completion level

Behaviour:
- Reset (rst=1 at a clk edge) gives: state=IDLE, ptr=0, ack=0, res=0, err=0, busy=0, mul_a=0, mul_b=0, mul_start=0, wdog=0.
- Reset mid-operation aborts the operation: no ack is issued, and the requester must keep req high to be served again.
- Requester rule: hold req and operands stable until ack. ack drops no earlier than the cycle after it is seen. If req is still high after ack, that is a new request.
- FSM IDLE:
  - If any req is set, grant the first set bit searching from ptr upward, wrapping at NREQ.
  - Register gnt (index), mul_a/mul_b from that requester's slice.
  - Go to START.
- FSM START:
  - mul_start=1 for exactly this cycle; wdog=0.
  - Go to WAIT.
- FSM WAIT:
  - mul_done is ignored in the first WAIT cycle, so a done left over from the previous operation is never taken as completion.
  - From the second WAIT cycle on, mul_done=1 latches res=mul_c and err=0, then goes to RESP.
  - Each WAIT cycle increments wdog. When wdog reaches TIMEOUT: res=0, err=1, go to RESP.
  - Done and timeout in the same cycle: done wins.
- FSM RESP:
  - ack[gnt]=1 for one cycle; ptr = (gnt+1) mod NREQ.
  - Go to IDLE.
  - ack, res and err are cleared in the following cycle.
- Minimum turnaround is 4 cycles plus multiplier latency (IDLE, START, WAIT, RESP). Back-to-back service always passes through IDLE.
- A requester that withdraws req while granted is still served; ack is issued regardless.
- Operands are captured at grant; later changes on op_a/op_b have no effect on that operation.
- res is taken from the multiplier unmodified. The product is 2W signed; no truncation or extension is applied.
- Fairness: a requester with req held waits at most NREQ-1 other operations.

Decomposition:
- Shared package booth_pkg holds:
  - the state encoding localparams S_IDLE=2'd0, S_START=2'd1, S_WAIT=2'd2, S_RESP=2'd3;
  - the slice helper macro for packed operand vectors.
- One sub-module rr_pick (combinational): inputs req and ptr, outputs index and a valid flag; lowest set bit at or after ptr with wraparound.
- Watchdog and FSM stay in booth_arbiter.
- The testbench instantiates booth_arbiter plus the existing Booth multiplier:
  - mul_start drives the multiplier's active-low rst through an inverter.
  - mul_c connects to the multiplier's c; mul_done connects to done.

Test Plan:
- Single request: req=0001, a0=5'b00010, b0=5'b11110. Expect ack=0001 once with res=10'b1111111100 (-4), err=0, busy low after.
- Simultaneous requests: req=1111 with (6,8), (4,1), (5,9), (-16,-16). Expect acks in order 0001, 0010, 0100, 1000 with res=48, 4, 45, 256.
- Fairness: req0 held continuously, req2 raised mid-operation. Expect order 0,2,0,2; ptr after the first ack is 1.
- Stale done: mul_done model holds done=1 after the previous operation. Expect no ack until a fresh done arrives; res equals the new product (6*8=48).
- Timeout: mul_done stuck 0, req=0100. After TIMEOUT WAIT cycles expect ack=0100, err=1, res=0. The next request proceeds normally.
- Reset mid-operation: assert rst for 1 cycle during WAIT. Expect all outputs 0 the next cycle and no ack; req1 still high is re-granted with ptr=0 priority.
